// File: rtl/hazard_control_unit.sv
// Decode-stage hazard controller: EX operand forwarding, load-use stall FSM,
// branch/jump flushing, and saturating stall/flush event counters.
module hazard_control_unit #(
    parameter int REGW       = 5,
    parameter int NSRC       = 2,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   RegWriteM,
    input  logic                   RegWriteW,
    input  logic                   MemReadE,
    input  logic [REGW-1:0]        RD_E,
    input  logic [REGW-1:0]        RD_M,
    input  logic [REGW-1:0]        RD_W,
    input  logic [NSRC*REGW-1:0]   Rs_D,
    input  logic [NSRC*REGW-1:0]   Rs_E,
    input  logic                   Branch_or_Jump,
    output logic [2*NSRC-1:0]      Forward,
    output logic                   StallF,
    output logic                   StallD,
    output logic                   FlushD,
    output logic                   FlushE,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt
);

    typedef enum logic {S_IDLE, S_STALL} state_t;

    localparam logic [2:0] REM_INIT = 3'(LOAD_STALL - 1);

    state_t           r_state, w_state_next;
    logic [2:0]       r_rem, w_rem_next;
    logic [NSRC-1:0]  w_fwd_m, w_fwd_w, w_src_hit;
    logic             w_luh, w_stall;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            assign w_fwd_m[gi]   = RegWriteM && (RD_M != '0) && (RD_M == Rs_E[gi*REGW +: REGW]);
            assign w_fwd_w[gi]   = RegWriteW && (RD_W != '0) && (RD_W == Rs_E[gi*REGW +: REGW]);
            // MEM result is younger than WB, so it wins when both match.
            assign Forward[2*gi +: 2] = w_fwd_m[gi] ? 2'b10 : (w_fwd_w[gi] ? 2'b01 : 2'b00);
            assign w_src_hit[gi] = (RD_E == Rs_D[gi*REGW +: REGW]);
        end
    endgenerate

    assign w_luh = MemReadE && (RD_E != '0) && (|w_src_hit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_rem   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_rem   <= w_rem_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rem_next   = r_rem;
        case (r_state)
            S_IDLE: begin
                if (w_luh && !Branch_or_Jump && (LOAD_STALL > 1)) begin
                    w_state_next = S_STALL;
                    w_rem_next   = REM_INIT;
                end
            end
            S_STALL: begin
                // A taken branch squashes the held load's dependent, so the stall is moot.
                if (Branch_or_Jump || (r_rem == 3'd1)) begin
                    w_state_next = S_IDLE;
                    w_rem_next   = 3'd0;
                end else begin
                    w_rem_next   = r_rem - 3'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_rem_next   = 3'd0;
            end
        endcase
    end

    always_comb begin
        w_stall = !Branch_or_Jump && ((r_state == S_STALL) || ((r_state == S_IDLE) && w_luh));
        StallF  = w_stall;
        StallD  = w_stall;
        FlushD  = Branch_or_Jump;
        FlushE  = Branch_or_Jump || w_stall;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (Branch_or_Jump && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: three parameterisations share one stimulus stream
// and are checked every cycle against a behavioural model plus literal expectations.
module tb_hazard_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegWriteM, RegWriteW, MemReadE, Branch_or_Jump;
    logic [4:0]  RD_E, RD_M, RD_W;
    logic [9:0]  Rs_D, Rs_E;

    logic [3:0]  fwd1, fwd3, fwd4;
    logic        sf1, sd1, fd1, fe1, sf3, sd3, fd3, fe3, sf4, sd4, fd4, fe4;
    logic [31:0] sc1, fc1, sc3, fc3;
    logic [3:0]  sc4, fc4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(.REGW(5), .NSRC(2), .LOAD_STALL(1), .CNT_W(32)) u_d1 (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReadE(MemReadE),
        .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W), .Rs_D(Rs_D), .Rs_E(Rs_E),
        .Branch_or_Jump(Branch_or_Jump), .Forward(fwd1), .StallF(sf1), .StallD(sd1),
        .FlushD(fd1), .FlushE(fe1), .stall_cnt(sc1), .flush_cnt(fc1));

    hazard_control_unit #(.REGW(5), .NSRC(2), .LOAD_STALL(3), .CNT_W(32)) u_d3 (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReadE(MemReadE),
        .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W), .Rs_D(Rs_D), .Rs_E(Rs_E),
        .Branch_or_Jump(Branch_or_Jump), .Forward(fwd3), .StallF(sf3), .StallD(sd3),
        .FlushD(fd3), .FlushE(fe3), .stall_cnt(sc3), .flush_cnt(fc3));

    hazard_control_unit #(.REGW(5), .NSRC(2), .LOAD_STALL(1), .CNT_W(4)) u_d4 (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReadE(MemReadE),
        .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W), .Rs_D(Rs_D), .Rs_E(Rs_E),
        .Branch_or_Jump(Branch_or_Jump), .Forward(fwd4), .StallF(sf4), .StallD(sd4),
        .FlushD(fd4), .FlushE(fe4), .stall_cnt(sc4), .flush_cnt(fc4));

    // ---------------- behavioural model ----------------
    int      m_left [3];
    longint  m_scnt [3];
    longint  m_fcnt [3];
    int      m_ls   [3] = '{1, 3, 1};
    longint  m_max  [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};

    function automatic logic [3:0] model_fwd();
        logic [3:0] f;
        logic [4:0] src;
        f = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            src = Rs_E[i*5 +: 5];
            if (RegWriteM && RD_M != 0 && RD_M == src)      f[2*i +: 2] = 2'b10;
            else if (RegWriteW && RD_W != 0 && RD_W == src) f[2*i +: 2] = 2'b01;
        end
        return f;
    endfunction

    function automatic logic model_luh();
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 2; i++)
            if (Rs_D[i*5 +: 5] == RD_E) hit = 1'b1;
        return MemReadE && RD_E != 0 && hit;
    endfunction

    function automatic logic model_stall(input int k);
        if (Branch_or_Jump) return 1'b0;
        return (m_left[k] > 0) || model_luh();
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                m_left[k] <= 0;
                m_scnt[k] <= 0;
                m_fcnt[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (Branch_or_Jump)     m_left[k] <= 0;
                else if (m_left[k] > 0) m_left[k] <= m_left[k] - 1;
                else if (model_luh())   m_left[k] <= m_ls[k] - 1;
                if (model_stall(k) && m_scnt[k] < m_max[k]) m_scnt[k] <= m_scnt[k] + 1;
                if (Branch_or_Jump && m_fcnt[k] < m_max[k]) m_fcnt[k] <= m_fcnt[k] + 1;
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [3:0]  a_fwd [3];
        logic        a_sf [3], a_sd [3], a_fd [3], a_fe [3];
        longint      a_sc [3], a_fc [3];
        logic        es;
        a_fwd = '{fwd1, fwd3, fwd4};
        a_sf  = '{sf1, sf3, sf4};
        a_sd  = '{sd1, sd3, sd4};
        a_fd  = '{fd1, fd3, fd4};
        a_fe  = '{fe1, fe3, fe4};
        a_sc  = '{longint'(sc1), longint'(sc3), longint'(sc4)};
        a_fc  = '{longint'(fc1), longint'(fc3), longint'(fc4)};
        for (int k = 0; k < 3; k++) begin
            es = (rst == 1'b1) ? model_stall(k) : (!Branch_or_Jump && model_luh());
            chk($sformatf("cyc_fwd[%0d]", k),    longint'(a_fwd[k]), longint'(model_fwd()));
            chk($sformatf("cyc_stallf[%0d]", k), longint'(a_sf[k]),  longint'(es));
            chk($sformatf("cyc_stalld[%0d]", k), longint'(a_sd[k]),  longint'(es));
            chk($sformatf("cyc_flushd[%0d]", k), longint'(a_fd[k]),  longint'(Branch_or_Jump));
            chk($sformatf("cyc_flushe[%0d]", k), longint'(a_fe[k]),  longint'(Branch_or_Jump | es));
            chk($sformatf("cyc_scnt[%0d]", k),   a_sc[k], m_scnt[k]);
            chk($sformatf("cyc_fcnt[%0d]", k),   a_fc[k], m_fcnt[k]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic clear_in();
        RegWriteM = 0; RegWriteW = 0; MemReadE = 0; Branch_or_Jump = 0;
        RD_E = 0; RD_M = 0; RD_W = 0; Rs_D = 0; Rs_E = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 0;
        #2;
        chk("rst_stalld", longint'(sd3), 0);
        chk("rst_scnt", longint'(sc3), 0);
        tick();
        rst = 1;
    endtask

    task automatic set_luh();
        MemReadE = 1; RD_E = 5'd3; Rs_D = {5'd3, 5'd0};
    endtask

    initial begin
        clear_in();
        #12;
        chk("reset_fwd", longint'(fwd1), 0);
        chk("reset_stall", longint'({sf1, sd1, fd1, fe1}), 0);
        chk("reset_cnt", longint'(fc1), 0);
        tick();
        rst = 1;

        // forwarding priority
        RegWriteM = 1; RD_M = 5; RegWriteW = 1; RD_W = 5; Rs_E = {5'd7, 5'd5};
        #2 chk("fwd_mem_prio", longint'(fwd1), longint'(4'b0010));
        RD_M = 0;
        #2 chk("fwd_wb", longint'(fwd1), longint'(4'b0001));
        Rs_E = {5'd5, 5'd0}; RD_W = 0;
        #2 chk("fwd_rd0", longint'(fwd1), 0);
        tick();
        clear_in();
        MemReadE = 1; RD_E = 0; Rs_D = 0;
        #2 chk("luh_rd0", longint'(sd1), 0);
        tick();

        // load-use, LOAD_STALL 1 and 3
        do_reset();
        set_luh();
        #2;
        chk("luh_d1_stall", longint'({sf1, sd1, fe1, fd1}), longint'(4'b1110));
        chk("luh_d3_stall", longint'(sd3), 1);
        tick();
        clear_in();
        #2;
        chk("luh_d1_done", longint'(sd1), 0);
        chk("luh_d3_c1", longint'(sd3), 1);
        tick();
        #2;
        chk("luh_d3_c2", longint'(sd3), 1);
        chk("luh_d1_cnt", longint'(sc1), 1);
        tick();
        #2;
        chk("luh_d3_done", longint'(sd3), 0);
        chk("luh_d3_cnt", longint'(sc3), 3);

        // branch and load-use in the same cycle
        do_reset();
        set_luh();
        Branch_or_Jump = 1;
        #2 chk("bj_luh_same", longint'({sd3, fd3, fe3}), longint'(3'b011));
        tick();
        clear_in();
        #2;
        chk("bj_luh_idle", longint'(sd3), 0);
        chk("bj_luh_fcnt", longint'(fc3), 1);
        chk("bj_luh_scnt", longint'(sc3), 0);

        // branch in second stall cycle
        do_reset();
        set_luh();
        tick();
        clear_in();
        Branch_or_Jump = 1;
        #2 chk("bj_mid_stall", longint'({sd3, fd3}), longint'(2'b01));
        tick();
        Branch_or_Jump = 0;
        #2;
        chk("bj_mid_idle", longint'(sd3), 0);
        chk("bj_mid_scnt", longint'(sc3), 1);
        chk("bj_mid_fcnt", longint'(fc3), 1);

        // reset mid-stall
        do_reset();
        set_luh();
        tick();
        clear_in();
        #2 chk("rmid_stalling", longint'(sd3), 1);
        rst = 0;
        #1;
        chk("rmid_outs", longint'({sf3, sd3, fe3, fd3}), 0);
        chk("rmid_cnt", longint'(sc3), 0);
        tick();
        rst = 1;
        tick();
        #2 chk("rmid_resume", longint'(sd3), 0);

        // saturation
        do_reset();
        Branch_or_Jump = 1;
        for (int i = 0; i < 20; i++) tick();
        Branch_or_Jump = 0;
        #2;
        chk("sat_d4", longint'(fc4), 15);
        chk("sat_d1", longint'(fc1), 20);

        // mixed vectors over a small register range to exercise all match combos
        for (int i = 0; i < 40; i++) begin
            tick();
            RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            MemReadE  = 1'($urandom_range(0, 1));
            Branch_or_Jump = ($urandom_range(0, 5) == 0);
            RD_E = 5'($urandom_range(0, 3));
            RD_M = 5'($urandom_range(0, 3));
            RD_W = 5'($urandom_range(0, 3));
            Rs_D = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            Rs_E = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
        end
        tick();
        clear_in();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
